// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button front end of the stopwatch.
//   - Debounce FSM state encoding (2-bit, legacy-compatible constants).
//   - Default timing constants for a 50 MHz system clock.
// No ports (package).
// ----------------------------------------------------------------------------
package button_pkg;

    // Debounce FSM states
    localparam logic [1:0] ST_IDLE         = 2'b00;  // stable level 0
    localparam logic [1:0] ST_PRESS_WAIT   = 2'b01;  // counting s2=1 cycles
    localparam logic [1:0] ST_PRESSED      = 2'b10;  // stable level 1
    localparam logic [1:0] ST_RELEASE_WAIT = 2'b11;  // counting s2=0 cycles

    // 10 ms and 2 s at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int LONG_CYCLES_DEFAULT     = 100000000;

endpackage

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// One button channel: 2-flop synchroniser (s1 -> s2), counter-based debounce
// FSM, registered debounced level and a single-cycle pulse per accepted press.
//
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  synchronous active-low reset
//   raw    in  1  asynchronous raw button, active-high
//   level  out 1  debounced level
//   pulse  out 1  one-cycle pulse when a press is accepted (never on release)
//   state  out 2  current FSM state (debug / used by long-press logic)
// ----------------------------------------------------------------------------
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    output logic       level,
    output logic       pulse,
    output logic [1:0] state
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_DONE = CW'(DEBOUNCE_CYCLES);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    // Saturating increment: the counter can never wrap back to a small value.
    assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
            state <= ST_IDLE;
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s2) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s2) begin
                        // bounce: drop the partial count silently
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                        level <= 1'b1;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (!s2) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s2) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        // release is accepted without a pulse
                        state <= ST_IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
// Front-end input stage for the stopwatch: two independent debounced button
// channels (start, reset), each producing a clean level and a one-cycle
// press pulse. The channels are not arbitrated against each other.
//
// Optional feature, macro BUTTON_CONDITIONER_LONGPRESS_EN:
//   defined   - reset channel gets a hold counter; reset_long_pulse fires
//               once, LONG_CYCLES edges after the channel enters PRESSED.
//   undefined - reset_long_pulse is tied to 0, no hold counter.
//
// Ports:
//   clk              in  1  system clock
//   rst_n            in  1  synchronous active-low reset
//   start_raw        in  1  raw start button (async, active-high)
//   reset_raw        in  1  raw reset button (async, active-high)
//   start_pulse      out 1  one-cycle pulse per accepted start press
//   reset_pulse      out 1  one-cycle pulse per accepted reset press
//   start_level      out 1  debounced start level
//   reset_level      out 1  debounced reset level
//   reset_long_pulse out 1  one-cycle pulse on a long reset hold
// ----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_raw,
    input  logic reset_raw,
    output logic start_pulse,
    output logic reset_pulse,
    output logic start_level,
    output logic reset_level,
    output logic reset_long_pulse
);

    logic [1:0] start_state;
    logic [1:0] rst_state;
    logic       unused_dbg;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (start_raw),
        .level (start_level),
        .pulse (start_pulse),
        .state (start_state)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (reset_raw),
        .level (reset_level),
        .pulse (reset_pulse),
        .state (rst_state)
    );

`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
    localparam int            HW        = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_cnt;
    logic          long_q;

    // Counter is zero whenever the channel is outside PRESSED, so entry to
    // PRESSED always starts from 0. It saturates at LONG_CYCLES so the pulse
    // fires once per press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (rst_state == ST_PRESSED) begin
                if (hold_cnt != HOLD_DONE) begin
                    hold_cnt <= hold_cnt + HW'(1);
                    if (hold_cnt + HW'(1) == HOLD_DONE) begin
                        long_q <= 1'b1;
                    end
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    assign reset_long_pulse = long_q;
    assign unused_dbg       = ^start_state;
`else
    assign reset_long_pulse = 1'b0;
    assign unused_dbg       = ^{start_state, rst_state, (LONG_CYCLES > 0)};
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4 and
// LONG_CYCLES=8. Output vector order everywhere:
//   {start_pulse, reset_pulse, start_level, reset_level, reset_long_pulse}
// The reference model describes each channel as "a new synchronised level
// must be seen for D consecutive edges before it is accepted".
// ----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 8;
`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic start_raw;
    logic reset_raw;
    logic start_pulse;
    logic reset_pulse;
    logic start_level;
    logic reset_level;
    logic reset_long_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_raw        (start_raw),
        .reset_raw        (reset_raw),
        .start_pulse      (start_pulse),
        .reset_pulse      (reset_pulse),
        .start_level      (start_level),
        .reset_level      (reset_level),
        .reset_long_pulse (reset_long_pulse)
    );

    // ---------------- reference model (pre-edge state) ----------------
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl[2];
    int m_run[2];   // consecutive edges s2 has differed from the accepted level
    bit m_pulse[2];
    int m_hold;     // edges spent stably pressed (reset channel)
    bit m_long;

    function automatic void model_edge(bit raw0, bit raw1, bit rstn);
        bit raws[2];
        bit stably_pressed;
        raws[0] = raw0;
        raws[1] = raw1;
        if (!rstn) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_pulse[c] = 0;
            end
            m_hold = 0;
            m_long = 0;
            return;
        end
        stably_pressed = m_lvl[1] && (m_run[1] == 0);
        for (int c = 0; c < 2; c++) begin
            m_pulse[c] = 0;
            if (m_s2[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_lvl[c]   = !m_lvl[c];
                    m_run[c]   = 0;
                    m_pulse[c] = m_lvl[c];
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_long = 0;
        if (stably_pressed) begin
            if (m_hold < L) begin
                m_hold++;
                m_long = LONG_EN && (m_hold == L);
            end
        end else begin
            m_hold = 0;
        end
        for (int c = 0; c < 2; c++) begin
            m_s2[c] = m_s1[c];
            m_s1[c] = raws[c];
        end
    endfunction

    function automatic logic [4:0] model_out();
        return {m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1], m_long};
    endfunction

    function automatic logic [4:0] dut_out();
        return {start_pulse, reset_pulse, start_level, reset_level, reset_long_pulse};
    endfunction

    // ---------------- driver / checker ----------------
    // Drive inputs just after an edge, advance the model, sample #1 after
    // the next rising edge.
    task automatic step(input bit sr, input bit rr, input bit rn);
        start_raw = sr;
        reset_raw = rr;
        rst_n     = rn;
        model_edge(sr, rr, rn);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         sr;
        bit         rr;
        bit         rn;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(bit sr, bit rr, bit rn, logic [4:0] exp);
        vec_t v;
        v.sr = sr; v.rr = rr; v.rn = rn; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        int pulses;
        int left[2];
        bit cur[2];
        bit rn_r;

        start_raw = 0;
        reset_raw = 0;
        rst_n     = 0;

        // Clean start press from idle: pulse at E5, level 1 from E5;
        // release: level stays 1 through F4, drops at F5.
        for (int i = 0; i < 5; i++) add_vec(1, 0, 1, 5'b00000);
        add_vec(1, 0, 1, 5'b10100);
        add_vec(1, 0, 1, 5'b00100);
        add_vec(1, 0, 1, 5'b00100);
        for (int i = 0; i < 5; i++) add_vec(0, 0, 1, 5'b00100);
        add_vec(0, 0, 1, 5'b00000);
        add_vec(0, 0, 1, 5'b00000);

        // ---- reset with toggling raw inputs ----
        for (int i = 0; i < 3; i++) begin
            step(i[0], !i[0], 0);
            check("reset_hold", dut_out(), 5'b00000);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1);
            check("after_reset", dut_out(), 5'b00000);
        end

        // ---- table: clean press / release ----
        foreach (vecs[i]) begin
            step(vecs[i].sr, vecs[i].rr, vecs[i].rn);
            check($sformatf("clean_vec%0d", i), dut_out(), vecs[i].exp);
        end

        // ---- bounce: 3 high, 1 low, 2 high, low -> nothing ----
        pulses = 0;
        begin
            bit pat[12];
            pat = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
            for (int i = 0; i < 12; i++) begin
                step(pat[i], 0, 1);
                check("bounce_model", dut_out(), model_out());
                if (start_pulse || start_level) pulses++;
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL bounce_no_accept: got %0d active cycles expected 0", pulses);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1);
            check("bounce_hold_model", dut_out(), model_out());
            pulses += int'(start_pulse);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1);
            pulses += int'(start_pulse);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_then_hold: got %0d pulses expected 1", pulses);
        end

        // ---- simultaneous press ----
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 1);
            if (i == 5) check("simul_E5", dut_out(), 5'b11110);
            else if (i < 5) check("simul_pre", dut_out(), 5'b00000);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        check("simul_released", dut_out(), 5'b00000);

        // ---- reset mid-count ----
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1);
            check("midcount_pre", dut_out(), 5'b00000);
        end
        step(1, 0, 0);
        check("midcount_rst", dut_out(), 5'b00000);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1);
            check("midcount_post", {start_pulse, start_level},
                  (i == 5) ? 5'b00011 : (i > 5) ? 5'b00001 : 5'b00000);
            pulses += int'(start_pulse);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL midcount_pulses: got %0d expected 1", pulses);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1);

        // ---- long press on reset channel ----
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1);
            check($sformatf("long_E%0d", i), {reset_pulse, reset_long_pulse},
                  {3'b000, (i == 5), (LONG_EN && i == 13)});
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1);
            check("long_release", {reset_pulse, reset_long_pulse}, 5'b00000);
        end

        // ---- randomized run against the model ----
        left[0] = 0; left[1] = 0; cur[0] = 0; cur[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (left[c] == 0) begin
                    cur[c]  = 1'($urandom_range(0, 1));
                    left[c] = $urandom_range(1, 20);
                end
                left[c]--;
            end
            rn_r = ($urandom_range(0, 299) != 0);
            step(cur[0], cur[1], rn_r);
            check("random", dut_out(), model_out());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input stage for the stopwatch. Takes the two raw, bouncing push-button inputs (start, reset), synchronises each to `clk` and debounces it with a counter-based state machine. Each confirmed press produces a clean single-cycle pulse that drives the stopwatch's `button_start` and `button_reset` inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive cycles a new level must hold before it is accepted; legal range ≥2.
- `LONG_CYCLES`, default 100000000 (2 s at 50 MHz): further hold cycles after an accepted press before the long-press pulse fires. Used only when long-press is compiled in.
- `clk` in 1: system clock; the only clock in the block.
- `rst_n` in 1: reset, synchronous and active-low.
- `start_raw` in 1: asynchronous raw start button, active-high.
- `reset_raw` in 1: asynchronous raw reset button, active-high.
- `start_pulse` out 1: one-cycle pulse per accepted start press.
- `reset_pulse` out 1: one-cycle pulse per accepted reset press.
- `start_level` out 1: debounced start level.
- `reset_level` out 1: debounced reset level.
- `reset_long_pulse` out 1: one-cycle pulse when reset is held long; constant 0 when the feature is compiled out.

## Operation
- Each channel has a 2-flop synchroniser (`s1` to `s2`), reset to 0.
- Each channel has its own debounce FSM. All state changes happen on the `clk` rising edge.
  - IDLE: stable level 0.
  - PRESS_WAIT: counting `s2`=1 cycles.
  - PRESSED: stable level 1.
  - RELEASE_WAIT: counting `s2`=0 cycles.
- IDLE to PRESS_WAIT when `s2`=1; counter loads 1.
- In PRESS_WAIT:
  - `s2`=1: counter increments.
  - Counter reaches `DEBOUNCE_CYCLES` with `s2`=1: go to PRESSED, `level` goes to 1, `pulse` asserts for one cycle.
  - `s2`=0 at any point (bounce): return to IDLE, counter cleared, no pulse.
- PRESSED, RELEASE_WAIT and IDLE mirror the press path with polarities swapped. Release never generates a pulse.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter saturates and never wraps.
- The two channels are fully independent. Simultaneous presses produce `start_pulse` and `reset_pulse` in the same cycle when timing coincides. No priority is applied; arbitration belongs to the stopwatch.
- Reset (`rst_n`=0 at an edge):
  - FSMs go to IDLE; counters, synchronisers and all outputs go to 0.
  - This applies mid-count as well; a partially counted press is discarded.
  - A button held through reset is re-debounced after `rst_n` rises and yields one `pulse`.

## Timing
- Reset values: all outputs 0.
- Latency: raw rising before edge E0 gives `s2`=1 after E1. `pulse` and `level`=1 are visible after edge E1+`DEBOUNCE_CYCLES`.
- Release: `level`=0 after edge E1+`DEBOUNCE_CYCLES` relative to the falling raw edge.
- `pulse` is high for exactly one cycle per press regardless of hold time.
- A minimum of 2·`DEBOUNCE_CYCLES` cycles separates two accepted presses on one channel.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `BUTTON_CONDITIONER_LONGPRESS_EN`.
- Defined:
  - The reset channel has a hold counter, width `$clog2(LONG_CYCLES+1)`, cleared on entry to PRESSED and incremented while in PRESSED.
  - When the counter reaches `LONG_CYCLES`, `reset_long_pulse` fires one cycle and the counter saturates, so it fires once per press.
  - Leaving PRESSED or asserting reset clears the counter.
- Undefined: `reset_long_pulse` is tied to 0 and there is no hold counter. The port list is unchanged.

## Structure
- Shared package `button_pkg` holds:
  - FSM state encoding: IDLE=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11.
  - Default constants `DEBOUNCE_CYCLES_DEFAULT` and `LONG_CYCLES_DEFAULT`.
- Sub-module `button_debounce` contains one channel: synchroniser, FSM, counter, and the `level`/`pulse` outputs. It is instantiated twice.
- The top module adds the long-press logic on the reset channel under the macro.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=8.
- Reset: hold `rst_n`=0 for 3 cycles with both raw inputs toggling → all outputs 0 throughout; no pulse after release with raw inputs at 0.
- Clean press: `start_raw` 0→1 before E0, held → `start_pulse`=1 only in the cycle after E5, `start_level`=1 from E5. Release → `start_level`=0 four cycles after `s2` falls, with no pulse.
- Bounce: `start_raw` high for 3 cycles, low for 1, high for 2, then low → no pulse, `start_level` stays 0. Then holding high for ≥6 cycles → exactly one pulse.
- Simultaneous press: both raw inputs rise together → `start_pulse` and `reset_pulse` both high in the same cycle.
- Reset mid-count: raw high for 3 cycles, `rst_n`=0 for one edge, raw kept high → no pulse before reset; exactly one pulse 5 edges after `rst_n` rises.
- Long press, macro defined: `reset_raw` held for 20 cycles → `reset_pulse` at E5, `reset_long_pulse` once at E13, nothing further. Macro undefined → `reset_long_pulse` stays 0.
